// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the Avalon round-robin arbiter.
// State encoding, requester index constants, the "no grant" marker, the
// watchdog fill pattern and a modulo-3 rotation helper.
package avl_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam logic [1:0]  REQ_VID      = 2'd0;
   localparam logic [1:0]  REQ_AUD      = 2'd1;
   localparam logic [1:0]  REQ_SD       = 2'd2;
   localparam logic [1:0]  GRANT_NONE   = 2'd3;
   localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

   // Index reached by stepping 'step' places after 'base' around 0,1,2.
   // A base of GRANT_NONE behaves like the last slot, so index 0 comes next.
   function automatic logic [1:0] rr_offset(input logic [1:0] base,
                                            input logic [1:0] step);
      logic [2:0] sum;
      if (base == GRANT_NONE)
         sum = 3'd2 + {1'b0, step};
      else
         sum = {1'b0, base} + {1'b0, step};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way round-robin selector.
// Returns the first eligible index strictly after last_grant (mod 3).
module rr_pick
   import avl_arb_pkg::*;
(
   input  logic [2:0] elig_mask,
   input  logic [1:0] last_grant,
   output logic [1:0] pick_idx,
   output logic       pick_valid
);

   logic [2:0][1:0] cand_idx;
   logic [2:0]      cand_hit;
   logic [3:0]      mask_pad;

   // Padding lets the index lookup stay in range for every 2-bit value.
   assign mask_pad = {1'b0, elig_mask};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cand
         assign cand_idx[gi] = rr_offset(last_grant, 2'(gi + 1));
         assign cand_hit[gi] = mask_pad[cand_idx[gi]];
      end
   endgenerate

   // Nearest eligible candidate wins; scan far-to-near so near overwrites.
   always_comb begin
      pick_idx   = GRANT_NONE;
      pick_valid = 1'b0;
      for (int i = 2; i >= 0; i--) begin
         if (cand_hit[i]) begin
            pick_idx   = cand_idx[i];
            pick_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/avl_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon bridge master among two readers
// (video, audio) and one writer (SD loader). One transaction in flight at a
// time; word addresses become byte addresses on the bus.
// Optional watchdog: define AVL_ARB_TIMEOUT_EN to abort hung transactions.
module avl_rr_arbiter
   import avl_arb_pkg::*;
#(
   parameter int NREQ           = 3,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic                  clk50,
   input  logic                  reset_n,
   input  logic                  write_override,
   input  logic [1:0]            req_rd,
   input  logic                  req_wr,
   input  logic [NREQ-1:0][24:0] req_addr,
   input  logic [15:0]           wr_data,
   output logic [NREQ-1:0]       ack_out,
   output logic [15:0]           rd_data_out,
   output logic [25:0]           avl_addr,
   output logic                  avl_read,
   output logic                  avl_write,
   output logic [15:0]           avl_wrdata,
   input  logic [15:0]           avl_rddata,
   input  logic                  avl_ack,
   output logic [1:0]            grant_idx,
   output logic                  timeout_err
);

   arb_state_t  state_reg;
   logic [1:0]  last_grant_reg;
   logic [2:0]  elig_mask;
   logic [1:0]  pick_idx;
   logic        pick_valid;
   logic [24:0] pick_addr;
   logic        to_hit;
   logic        done;

   // Override restricts the eligible set to the SD writer only.
   assign elig_mask = write_override ? {req_wr, 2'b00} : {req_wr, req_rd};

   rr_pick u_pick (
      .elig_mask  (elig_mask),
      .last_grant (last_grant_reg),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   // Select the word address of the requester about to be granted.
   always_comb begin
      pick_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == 2'(i))
            pick_addr = req_addr[i];
      end
   end

   // Transaction ends on bridge ack or watchdog expiry; never while in reset.
   assign done = reset_n && (state_reg == BUSY) && (avl_ack || to_hit);

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ack
         assign ack_out[gi] = done && (grant_idx == 2'(gi));
      end
   endgenerate

   // Read data is passed through in the completion cycle, pattern on abort.
   always_comb begin
      rd_data_out = '0;
      if (done)
         rd_data_out = avl_ack ? avl_rddata : TIMEOUT_DATA;
   end

   // Main FSM with registered bus strobes, address, data and grant.
   always_ff @(posedge clk50) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= REQ_SD;
         grant_idx      <= GRANT_NONE;
         avl_read       <= 1'b0;
         avl_write      <= 1'b0;
         avl_addr       <= '0;
         avl_wrdata     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  state_reg  <= BUSY;
                  grant_idx  <= pick_idx;
                  avl_addr   <= {pick_addr, 1'b0};
                  avl_wrdata <= wr_data;
                  avl_read   <= (pick_idx != REQ_SD);
                  avl_write  <= (pick_idx == REQ_SD);
               end
            end
            BUSY: begin
               if (done) begin
                  state_reg      <= RELEASE;
                  last_grant_reg <= grant_idx;
                  grant_idx      <= GRANT_NONE;
                  avl_read       <= 1'b0;
                  avl_write      <= 1'b0;
               end
            end
            RELEASE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef AVL_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_reg;
   logic        timeout_err_reg;

   assign to_hit      = (state_reg == BUSY) && (to_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_err_reg;

   // Watchdog: count BUSY cycles from zero, latch a sticky error on expiry.
   always_ff @(posedge clk50) begin
      if (!reset_n) begin
         to_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (state_reg == BUSY)
            to_cnt_reg <= to_cnt_reg + 16'd1;
         else
            to_cnt_reg <= '0;
         if (to_hit && !avl_ack)
            timeout_err_reg <= 1'b1;
      end
   end
`else
   logic [31:0] unused_timeout_cfg;

   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign to_hit             = 1'b0;
   assign timeout_err        = 1'b0;
`endif

endmodule
